// File: rtl/fft_seq_pkg.sv
// ============================================================================
// fft_seq_pkg : shared types and helpers for the FFT frame sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fft_seq_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_buffer.sv
// ============================================================================
// fft_frame_buffer : N x BIT_WIDTH register file, serial write / parallel load
// Revision         : 1.0
// ============================================================================
`default_nettype none

module fft_frame_buffer
  import fft_seq_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int IDX_W     = idx_width(N_SAMPLES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [BIT_WIDTH-1:0]           wr_data_i,
  input  logic                           ld_en_i,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] ld_data_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic [BIT_WIDTH-1:0]           rd_data_o,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] frame_o
);

  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] mem_q;

  // A parallel load replaces the whole frame and wins over a serial write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else if (ld_en_i) begin
      mem_q <= ld_data_i;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign frame_o   = mem_q;

endmodule

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// ============================================================================
// fft_frame_sequencer : serial samples -> parallel FFT frame -> serial bins
// Revision            : 1.0
// ============================================================================
`default_nettype none

module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           in_msg_i,
  input  logic                           in_val_i,
  output logic                           in_rdy_o,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] fft_recv_msg_o,
  output logic                           fft_recv_val_o,
  input  logic                           fft_recv_rdy_i,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] fft_send_msg_i,
  input  logic                           fft_send_val_i,
  output logic                           fft_send_rdy_o,
  output logic [BIT_WIDTH-1:0]           out_msg_o,
  output logic                           out_val_o,
  input  logic                           out_rdy_i,
  output logic                           out_last_o,
  output logic                           busy_o
);

  localparam int               IDX_W    = idx_width(N_SAMPLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic                           in_wr_en;
  logic                           out_ld_en;
  logic [BIT_WIDTH-1:0]           out_word;
  logic [BIT_WIDTH-1:0]           in_rd_unused;
  logic [N_SAMPLES*BIT_WIDTH-1:0] out_frame_unused;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      FILL: begin
        if (in_val_i) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ISSUE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        if (fft_recv_rdy_i) state_d = WAIT;
      end
      WAIT: begin
        if (fft_send_val_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_rdy_i) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = FILL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake outputs decode state only, so no input reaches an output.
  assign in_rdy_o       = (state_q == FILL);
  assign fft_recv_val_o = (state_q == ISSUE);
  assign fft_send_rdy_o = (state_q == WAIT);
  assign out_val_o      = (state_q == DRAIN);
  assign out_msg_o      = (state_q == DRAIN) ? out_word : '0;
  assign out_last_o     = (state_q == DRAIN) && (idx_q == IDX_LAST);
  assign busy_o         = !((state_q == FILL) && (idx_q == '0));

  assign in_wr_en  = (state_q == FILL) && in_val_i;
  assign out_ld_en = (state_q == WAIT) && fft_send_val_i;

  fft_frame_buffer #(
    .BIT_WIDTH (BIT_WIDTH),
    .N_SAMPLES (N_SAMPLES),
    .IDX_W     (IDX_W)
  ) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (in_wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (in_msg_i),
    .ld_en_i   (1'b0),
    .ld_data_i ('0),
    .rd_idx_i  ('0),
    .rd_data_o (in_rd_unused),
    .frame_o   (fft_recv_msg_o)
  );

  fft_frame_buffer #(
    .BIT_WIDTH (BIT_WIDTH),
    .N_SAMPLES (N_SAMPLES),
    .IDX_W     (IDX_W)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (1'b0),
    .wr_idx_i  ('0),
    .wr_data_i ('0),
    .ld_en_i   (out_ld_en),
    .ld_data_i (fft_send_msg_i),
    .rd_idx_i  (idx_q),
    .rd_data_o (out_word),
    .frame_o   (out_frame_unused)
  );

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// ============================================================================
// tb_fft_frame_sequencer : directed + random frames against a stub FFT
// Revision               : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_frame_sequencer;

  localparam int BW = 32;
  localparam int N  = 8;
  localparam int FW = BW * N;
  typedef logic [FW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] in_msg;
  logic          in_val;
  logic          in_rdy;
  frame_t        fft_recv_msg;
  logic          fft_recv_val;
  logic          fft_recv_rdy;
  frame_t        fft_send_msg;
  logic          fft_send_val;
  logic          fft_send_rdy;
  logic [BW-1:0] out_msg;
  logic          out_val;
  logic          out_rdy;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int stub_hold = 0;
  int stub_lat  = 0;
  bit stub_spur = 1'b0;
  int recv_hs   = 0;
  int send_hs   = 0;
  int proto_bad = 0;
  frame_t recv_q[$];

  fft_frame_sequencer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_msg_i       (in_msg),
    .in_val_i       (in_val),
    .in_rdy_o       (in_rdy),
    .fft_recv_msg_o (fft_recv_msg),
    .fft_recv_val_o (fft_recv_val),
    .fft_recv_rdy_i (fft_recv_rdy),
    .fft_send_msg_i (fft_send_msg),
    .fft_send_val_i (fft_send_val),
    .fft_send_rdy_o (fft_send_rdy),
    .out_msg_o      (out_msg),
    .out_val_o      (out_val),
    .out_rdy_i      (out_rdy),
    .out_last_o     (out_last),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Real part of an 8-point DFT in Q16: the transform the stub FFT applies.
  function automatic frame_t dft_re(input frame_t x);
    longint c[8];
    longint acc;
    frame_t y;
    c = '{65536, 46341, 0, -46341, -65536, -46341, 0, 46341};
    y = '0;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int n = 0; n < N; n++)
        acc += (longint'($signed(x[n*BW +: BW])) * c[(k*n) % N]) >>> 16;
      y[k*BW +: BW] = acc[BW-1:0];
    end
    return y;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i*BW +: BW] = $urandom();
    return f;
  endfunction

  task automatic chk(input string tag, input frame_t obs, input frame_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Stub FFT: accepts a frame after stub_hold stall cycles, answers stub_lat later.
  initial begin
    frame_t stub_frame;
    fft_recv_rdy = 1'b0;
    fft_send_val = 1'b0;
    fft_send_msg = '0;
    forever begin
      @(negedge clk);
      if (fft_recv_val && !reset) begin
        repeat (stub_hold) @(negedge clk);
        fft_recv_rdy = 1'b1;
        stub_frame   = fft_recv_msg;
        @(negedge clk);
        fft_recv_rdy = 1'b0;
        repeat (stub_lat) @(negedge clk);
        fft_send_msg = dft_re(stub_frame);
        fft_send_val = 1'b1;
        @(negedge clk);
        fft_send_val = 1'b0;
        if (stub_spur) begin
          fft_send_msg = {N{32'hDEAD_BEEF}};
          fft_send_val = 1'b1;
          @(negedge clk);
          fft_send_val = 1'b0;
        end
      end
    end
  end

  // Protocol monitor, sampling 1 ns before each rising edge.
  initial begin
    frame_t last_issue;
    bit     in_issue = 1'b0;
    last_issue = '0;
    #4;
    forever begin
      if (fft_recv_val) begin
        if (fft_send_rdy) proto_bad++;
        if (in_issue && fft_recv_msg !== last_issue) proto_bad++;
        last_issue = fft_recv_msg;
        in_issue   = 1'b1;
        if (fft_recv_rdy) begin
          recv_hs++;
          recv_q.push_back(fft_recv_msg);
          in_issue = 1'b0;
        end
      end else begin
        in_issue = 1'b0;
      end
      if (fft_send_val && fft_send_rdy) send_hs++;
      #10;
    end
  end

  task automatic fill(input frame_t f, input int gap_pos, input int cnt);
    int t;
    for (int i = 0; i < cnt; i++) begin
      if (i == gap_pos) begin
        in_val = 1'b0;
        repeat (3) @(negedge clk);
      end
      in_msg = f[i*BW +: BW];
      in_val = 1'b1;
      t = 0;
      while (!in_rdy && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        chk("fill_in_rdy_timeout", frame_t'(in_rdy), 1);
        in_val = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_val = 1'b0;
    if (cnt == N) chk("in_rdy_after_8th", frame_t'(in_rdy), 0);
  endtask

  // bp: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic drain(input frame_t expv, input int nbins, input int bp);
    int k = 0;
    int cyc = 0;
    int t = 0;
    logic [BW-1:0] held = '0;
    bit holding = 1'b0;
    while (k < nbins) begin
      if (t > 200) begin
        chk("drain_out_val_timeout", frame_t'(out_val), 1);
        out_rdy = 1'b0;
        return;
      end
      if (!out_val) begin
        out_rdy = 1'b0;
        t++;
        @(negedge clk);
        continue;
      end
      if (holding) chk("out_msg_stable", frame_t'(out_msg), frame_t'(held));
      case (bp)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      chk("in_rdy_in_drain", frame_t'(in_rdy), 0);
      if (out_rdy) begin
        chk($sformatf("bin%0d_msg", k), frame_t'(out_msg), frame_t'(expv[k*BW +: BW]));
        chk($sformatf("bin%0d_last", k), frame_t'(out_last), frame_t'(k == N - 1));
        k++;
        holding = 1'b0;
      end else begin
        held    = out_msg;
        holding = 1'b1;
      end
      @(negedge clk);
    end
    out_rdy = 1'b0;
    if (nbins == N) begin
      chk("in_rdy_after_drain", frame_t'(in_rdy), 1);
      chk("out_val_after_drain", frame_t'(out_val), 0);
    end
  endtask

  task automatic run(input frame_t f, input frame_t expv, input int gap_pos, input int bp,
                     input int nbins);
    int r0 = recv_hs;
    int s0 = send_hs;
    fill(f, gap_pos, N);
    drain(expv, nbins, bp);
    chk("recv_handshakes", frame_t'(recv_hs - r0), 1);
    chk("send_handshakes", frame_t'(send_hs - s0), 1);
    if (recv_q.size() == 0) chk("recv_frame_count", frame_t'(recv_q.size()), 1);
    else chk("recv_frame_order", recv_q.pop_front(), f);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_rdy"}, frame_t'(in_rdy), 1);
    chk({tag, "_busy"}, frame_t'(busy), 0);
    chk({tag, "_out_val"}, frame_t'(out_val), 0);
    chk({tag, "_out_msg"}, frame_t'(out_msg), 0);
    chk({tag, "_out_last"}, frame_t'(out_last), 0);
    chk({tag, "_recv_val"}, frame_t'(fft_recv_val), 0);
    chk({tag, "_send_rdy"}, frame_t'(fft_send_rdy), 0);
    chk({tag, "_recv_msg"}, fft_recv_msg, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t imp, imp_exp, dc, dc_exp, ramp, rf;
    for (int i = 0; i < N; i++) begin
      imp[i*BW +: BW]     = (i == 0) ? 32'h0001_0000 : 32'h0;
      imp_exp[i*BW +: BW] = 32'h0001_0000;
      dc[i*BW +: BW]      = 32'h0001_0000;
      dc_exp[i*BW +: BW]  = (i == 0) ? 32'h0008_0000 : 32'h0;
      ramp[i*BW +: BW]    = 32'(i) << 16;
    end

    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);

    run(imp, imp_exp, -1, 0, N);
    run(dc, dc_exp, -1, 0, N);
    run(dc, dc_exp, 4, 1, N);

    stub_hold = 5;
    stub_lat  = 4;
    stub_spur = 1'b1;
    rf = rand_frame();
    run(rf, dft_re(rf), -1, 1, N);
    stub_hold = 0;
    stub_lat  = 0;
    stub_spur = 1'b0;

    // Asynchronous reset in FILL with 5 samples taken.
    fill(rand_frame(), -1, 5);
    chk("busy_mid_fill", frame_t'(busy), 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_fill");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(imp, imp_exp, -1, 0, N);

    // Asynchronous reset in DRAIN after 3 bins consumed.
    run(dc, dc_exp, -1, 0, 3);
    chk("busy_mid_drain", frame_t'(busy), 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_drain");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(imp, imp_exp, -1, 0, N);

    run(imp, imp_exp, -1, 0, N);
    run(dc, dc_exp, -1, 0, N);
    run(ramp, dft_re(ramp), -1, 0, N);

    for (int j = 0; j < 3; j++) begin
      stub_hold = int'($urandom_range(0, 3));
      stub_lat  = int'($urandom_range(0, 5));
      rf = rand_frame();
      run(rf, dft_re(rf), int'($urandom_range(1, 7)), 2, N);
    end

    chk("protocol_violations", frame_t'(proto_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
